sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 123 ++++++++++++
 tb/tb_sync_fifo_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with almost-full/almost-empty flags and sticky overflow/underflow.
// Latency: write-to-readable 1 cycle; read data 1 cycle after pop (FWFT=0) or head shown directly (FWFT=1).
// Backpressure: writes rejected while full, reads rejected while empty; rejected attempts set ovf_o/udf_o.
module sync_fifo_param #(
   parameter int DATA_W    = 64,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0
) (
   input  logic                      axi_clk,
   input  logic                      axi_resetn,
   input  logic                      flush_i,
   input  logic                      wr_en_i,
   input  logic [DATA_W-1:0]         wr_data_i,
   output logic                      wr_full_o,
   output logic                      wr_afull_o,
   input  logic                      rd_en_i,
   output logic [DATA_W-1:0]         rd_data_o,
   output logic                      rd_valid_o,
   output logic                      rd_empty_o,
   output logic                      rd_aempty_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      ovf_o,
   output logic                      udf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
   localparam logic [CW-1:0] C_AFULL_TH  = CW'(AFULL_TH);
   localparam logic [CW-1:0] C_AEMPTY_TH = CW'(AEMPTY_TH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_ovf;
   logic              r_udf;

   logic              w_full;
   logic              w_empty;
   logic              w_wr_acc;
   logic              w_rd_acc;

   // Status comes only from the registered count, so a same-cycle read never frees room for a write
   // and a same-cycle write never makes a read legal.
   assign w_full   = (r_count == C_DEPTH);
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = wr_en_i & ~w_full & ~flush_i;
   assign w_rd_acc = rd_en_i & ~w_empty & ~flush_i;

   assign wr_full_o   = w_full;
   assign rd_empty_o  = w_empty;
   assign wr_afull_o  = (r_count >= C_AFULL_TH);
   assign rd_aempty_o = (r_count <= C_AEMPTY_TH);
   assign count_o     = r_count;
   assign ovf_o       = r_ovf;
   assign udf_o       = r_udf;

   // Storage array: no reset, written only on an accepted write.
   always_ff @(posedge axi_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= wr_data_i;
      end
   end

   // Pointers, occupancy and sticky error flags; flush returns everything to the empty state.
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         // DEPTH is a power of two, so natural overflow of the pointer is the modulo wrap.
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + CW'(1);
         end else if (!w_wr_acc && w_rd_acc) begin
            r_count <= r_count - CW'(1);
         end
         if (wr_en_i && w_full)  r_ovf <= 1'b1;
         if (rd_en_i && w_empty) r_udf <= 1'b1;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head entry is shown directly; zero while empty so reset/empty never exposes stale memory.
         assign rd_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
         assign rd_valid_o = ~w_empty;
      end else begin : g_reg
         logic [DATA_W-1:0] r_rd_data;
         logic              r_rd_valid;

         // Registered read: capture the head on a pop, valid for exactly the following cycle.
         always_ff @(posedge axi_clk or negedge axi_resetn) begin
            if (!axi_resetn) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_rd_data <= r_mem[r_rd_ptr];
               end
            end
         end

         assign rd_data_o  = r_rd_data;
         assign rd_valid_o = r_rd_valid;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: registered-read instance plus a first-word-fall-through instance.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected data is queued on accepted writes and popped whenever the DUT presents valid read data.
module tb_sync_fifo_param;

   localparam int DW  = 64;
   localparam int DEP = 8;

   logic          axi_clk = 1'b0;
   logic          axi_resetn = 1'b0;
   logic          flush_i = 1'b0;
   logic          wr_en_i = 1'b0;
   logic [DW-1:0] wr_data_i = '0;
   logic          rd_en_i = 1'b0;
   logic          wr_full_o, wr_afull_o, rd_valid_o, rd_empty_o, rd_aempty_o, ovf_o, udf_o;
   logic [DW-1:0] rd_data_o;
   logic [3:0]    count_o;

   logic          fw_flush = 1'b0;
   logic          fw_wr_en = 1'b0;
   logic [DW-1:0] fw_wr_data = '0;
   logic          fw_rd_en = 1'b0;
   logic          fw_full, fw_afull, fw_valid, fw_empty, fw_aempty, fw_ovf, fw_udf;
   logic [DW-1:0] fw_rd_data;
   logic [3:0]    fw_count;

   int            n_tot = 0;
   int            n_bad = 0;

   int            m_cnt = 0;
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;
   logic [DW-1:0] m_last = '0;
   logic [DW-1:0] sb_q [$];

   always #5 axi_clk = ~axi_clk;

   sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(0)) u_dut (
      .axi_clk     (axi_clk),
      .axi_resetn  (axi_resetn),
      .flush_i     (flush_i),
      .wr_en_i     (wr_en_i),
      .wr_data_i   (wr_data_i),
      .wr_full_o   (wr_full_o),
      .wr_afull_o  (wr_afull_o),
      .rd_en_i     (rd_en_i),
      .rd_data_o   (rd_data_o),
      .rd_valid_o  (rd_valid_o),
      .rd_empty_o  (rd_empty_o),
      .rd_aempty_o (rd_aempty_o),
      .count_o     (count_o),
      .ovf_o       (ovf_o),
      .udf_o       (udf_o)
   );

   sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1)) u_fw (
      .axi_clk     (axi_clk),
      .axi_resetn  (axi_resetn),
      .flush_i     (fw_flush),
      .wr_en_i     (fw_wr_en),
      .wr_data_i   (fw_wr_data),
      .wr_full_o   (fw_full),
      .wr_afull_o  (fw_afull),
      .rd_en_i     (fw_rd_en),
      .rd_data_o   (fw_rd_data),
      .rd_valid_o  (fw_valid),
      .rd_empty_o  (fw_empty),
      .rd_aempty_o (fw_aempty),
      .count_o     (fw_count),
      .ovf_o       (fw_ovf),
      .udf_o       (fw_udf)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge axi_clk);
      #1;
   endtask

   // Flags and count of the registered-read instance against the bench model.
   task automatic chk_status();
      chk("count",  DW'(count_o),     DW'(m_cnt));
      chk("full",   DW'(wr_full_o),   DW'(m_cnt == DEP));
      chk("empty",  DW'(rd_empty_o),  DW'(m_cnt == 0));
      chk("afull",  DW'(wr_afull_o),  DW'(m_cnt >= DEP - 2));
      chk("aempty", DW'(rd_aempty_o), DW'(m_cnt <= 2));
      chk("ovf",    DW'(ovf_o),       DW'(m_ovf));
      chk("udf",    DW'(udf_o),       DW'(m_udf));
   endtask

   // One clock of stimulus on the registered-read instance, with model update and checks.
   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
      logic wacc, racc;
      wr_en_i = w; wr_data_i = d; rd_en_i = r; flush_i = f;
      wacc = w && (m_cnt < DEP) && !f;
      racc = r && (m_cnt > 0) && !f;
      if (f) begin
         m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
         sb_q.delete();
      end else begin
         if (w && m_cnt == DEP) m_ovf = 1'b1;
         if (r && m_cnt == 0)   m_udf = 1'b1;
         if (wacc) sb_q.push_back(d);
         m_cnt = m_cnt + int'(wacc) - int'(racc);
      end
      tick();
      wr_en_i = 1'b0; rd_en_i = 1'b0; flush_i = 1'b0;
      chk("valid", DW'(rd_valid_o), DW'(racc));
      if (rd_valid_o) begin
         if (sb_q.size() == 0) begin
            chk("sb_underrun", DW'(rd_valid_o), '0);
         end else begin
            m_last = sb_q.pop_front();
            chk("data", rd_data_o, m_last);
         end
      end
      chk_status();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_count"},  DW'(count_o),     '0);
      chk({tag, "_full"},   DW'(wr_full_o),   '0);
      chk({tag, "_afull"},  DW'(wr_afull_o),  '0);
      chk({tag, "_empty"},  DW'(rd_empty_o),  DW'(1));
      chk({tag, "_aempty"}, DW'(rd_aempty_o), DW'(1));
      chk({tag, "_valid"},  DW'(rd_valid_o),  '0);
      chk({tag, "_data"},   rd_data_o,        '0);
      chk({tag, "_ovf"},    DW'(ovf_o),       '0);
      chk({tag, "_udf"},    DW'(udf_o),       '0);
      chk({tag, "_fwvalid"}, DW'(fw_valid),   '0);
      chk({tag, "_fwdata"},  fw_rd_data,      '0);
   endtask

   initial begin
      // Reset values while reset is held, before any clock edge.
      #2;
      chk_reset_outputs("rst");
      @(posedge axi_clk); @(posedge axi_clk); #1;
      axi_resetn = 1'b1;

      // Fill 1..8, then attempt 9 while full.
      for (int i = 1; i <= DEP; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
      cyc(1'b1, DW'(9), 1'b0, 1'b0);
      // Drain: data must come back 1..8 in order.
      for (int i = 0; i < DEP; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("last_read", m_last, DW'(8));
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk("hold", rd_data_o, DW'(8));

      // Read on empty.
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);

      // Simultaneous read and write at count 3, 8 and 0.
      for (int i = 0; i < 3; i++) cyc(1'b1, DW'(16'h100 + i), 1'b0, 1'b0);
      cyc(1'b1, DW'(16'h103), 1'b1, 1'b0);
      for (int i = 4; i < 9; i++) cyc(1'b1, DW'(16'h100 + i), 1'b0, 1'b0);
      cyc(1'b1, DW'(16'h1FF), 1'b1, 1'b0);
      while (m_cnt > 0) cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b1, DW'(16'h200), 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);

      // Wrap-around with count oscillating 0..2.
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0);
         cyc(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0);
         cyc(1'b0, '0, 1'b1, 1'b0);
         cyc(1'b0, '0, 1'b1, 1'b0);
      end

      // Flush at count 5 with a concurrent write, after setting ovf is not possible here, so just clear.
      for (int i = 0; i < 5; i++) cyc(1'b1, DW'(16'h300 + i), 1'b0, 1'b0);
      cyc(1'b1, DW'(16'h3FF), 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle with count 4 and a read in flight.
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, DW'(16'h400 + i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      #3;
      axi_resetn = 1'b0;
      #1;
      chk_reset_outputs("arst");
      m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
      sb_q.delete();
      tick();
      chk_reset_outputs("arst_hold");
      axi_resetn = 1'b1;
      // First edge after release must accept a write.
      cyc(1'b1, DW'(16'h500), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // First-word-fall-through instance.
      fw_wr_en = 1'b1; fw_wr_data = DW'(16'hA);
      tick();
      chk("fw_valid_a", DW'(fw_valid), DW'(1));
      chk("fw_data_a",  fw_rd_data,    DW'(16'hA));
      fw_wr_data = DW'(16'hB);
      tick();
      fw_wr_en = 1'b0;
      chk("fw_count2",  DW'(fw_count), DW'(2));
      chk("fw_data_a2", fw_rd_data,    DW'(16'hA));
      fw_rd_en = 1'b1;
      tick();
      chk("fw_valid_b", DW'(fw_valid), DW'(1));
      chk("fw_data_b",  fw_rd_data,    DW'(16'hB));
      tick();
      fw_rd_en = 1'b0;
      chk("fw_valid_end", DW'(fw_valid), '0);
      chk("fw_empty_end", DW'(fw_empty), DW'(1));
      chk("fw_udf_end",   DW'(fw_udf),   '0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
